// File: rtl/freelist_pkg.sv
// ----------------------------------------------------------------------------
// freelist_pkg
// Shared sizing and types for the rename-stage physical-register free list.
//   FL_SIZE      : number of free-list entries (physical regs beyond the
//                  32 architectural ones)
//   FL_SIZE_LOG  : log2(FL_SIZE)
//   ARCH_REGS    : architectural register count; preg ids start here
//   PREG_W       : width of a physical register id (PREG_RANGE)
//   flPtr_t      : {flag, idx} ring pointer; the flag tells a full ring
//                  from an empty one when the indices match
//   flPtrAdd     : pointer + n, wrapping modulo 2*FL_SIZE
// ----------------------------------------------------------------------------
package freelist_pkg;

    localparam int FL_SIZE     = 32;
    localparam int FL_SIZE_LOG = 5;
    localparam int ARCH_REGS   = 32;
    localparam int PREG_W      = $clog2(FL_SIZE + ARCH_REGS);

    typedef logic [PREG_W-1:0]      preg_t;
    typedef logic [FL_SIZE_LOG:0]   flCount_t;

    typedef struct packed {
        logic                   flag;
        logic [FL_SIZE_LOG-1:0] idx;
    } flPtr_t;

    // Adding in the full {flag, idx} width makes the index carry roll
    // straight into the flag, which is exactly the mod 2*FL_SIZE wrap.
    function automatic flPtr_t flPtrAdd(input flPtr_t ptr, input logic [1:0] n);
        logic [FL_SIZE_LOG:0] sum;
        sum = ptr + {{(FL_SIZE_LOG-1){1'b0}}, n};
        return sum;
    endfunction

endpackage

// File: rtl/freelist_if.sv
// ----------------------------------------------------------------------------
// freelist_if
// Bundles the rename allocation port, the two ROB commit slots, the redirect
// and the free count between the free list and its neighbours.
//   master : rename/ROB side (drives requests, commits, redirect)
//   slave  : free list (drives alloc_ready, alloc prds, free_count)
// ----------------------------------------------------------------------------
interface freelist_if;
    import freelist_pkg::*;

    logic     alloc0_req;
    logic     alloc1_req;
    logic     alloc_ready;
    preg_t    alloc0_prd;
    preg_t    alloc1_prd;

    logic     commits0_valid;
    logic     commits0_need_free;
    preg_t    commits0_old_prd;
    logic     commits1_valid;
    logic     commits1_need_free;
    preg_t    commits1_old_prd;

    logic     redirect_valid;
    flCount_t free_count;

    modport master (
        output alloc0_req, alloc1_req,
        output commits0_valid, commits0_need_free, commits0_old_prd,
        output commits1_valid, commits1_need_free, commits1_old_prd,
        output redirect_valid,
        input  alloc_ready, alloc0_prd, alloc1_prd, free_count
    );

    modport slave (
        input  alloc0_req, alloc1_req,
        input  commits0_valid, commits0_need_free, commits0_old_prd,
        input  commits1_valid, commits1_need_free, commits1_old_prd,
        input  redirect_valid,
        output alloc_ready, alloc0_prd, alloc1_prd, free_count
    );

endinterface

// File: rtl/freelist.sv
// ----------------------------------------------------------------------------
// freelist
// Physical-register free list for rename. Hands out up to two free pregs per
// cycle, reclaims up to two old pregs per cycle from ROB commit, and on a
// redirect rolls the speculative head back to the committed head.
//   clock   : single clock
//   reset_n : asynchronous active-low reset (list returns to full, 32..63)
//   fl      : freelist_if.slave (alloc, commit, redirect, free_count)
// ----------------------------------------------------------------------------
module freelist
    import freelist_pkg::*;
(
    input logic       clock,
    input logic       reset_n,
    freelist_if.slave fl
);

    flPtr_t   specHead_q, specHead_d;
    flPtr_t   archHead_q, archHead_d;
    flPtr_t   tail_q,     tail_d;
    flPtr_t   allocPtr1;
    flPtr_t   tailPlus1;

    preg_t    entries_q [FL_SIZE];

    flCount_t freeCount;
    logic     allocReady;
    logic     fire0, fire1;
    logic     reclaim0, reclaim1;
    logic [1:0] allocCnt, reclaimCnt;

    logic     firstWe, secondWe;
    preg_t    firstData, secondData;
    logic [FL_SIZE-1:0] entryWeFirst, entryWeSecond;

    // Allocation side. Occupancy comes only from registered pointers, so a
    // preg reclaimed this cycle cannot be handed out until the next one.
    // Redirect blocks allocation outright, and we insist on room for two
    // regardless of how many requests are up so rename can stall simply.
    // instr1 reads head+alloc0_req, so a lone instr1 request gets the head.
    always_comb begin
        freeCount  = tail_q - specHead_q;
        allocReady = (freeCount >= flCount_t'(2)) && !fl.redirect_valid;
        fire0      = fl.alloc0_req && allocReady;
        fire1      = fl.alloc1_req && allocReady;
        allocCnt   = {1'b0, fire0} + {1'b0, fire1};
        allocPtr1  = flPtrAdd(specHead_q, {1'b0, fl.alloc0_req});
    end

    assign fl.alloc_ready = allocReady;
    assign fl.free_count  = freeCount;
    assign fl.alloc0_prd  = entries_q[specHead_q.idx];
    assign fl.alloc1_prd  = entries_q[allocPtr1.idx];

    // Reclaim side. Only slots that actually allocated a prd return one,
    // and they are packed in slot order so a lone slot 1 still writes at
    // tail. The committed head moves in lockstep with the tail.
    always_comb begin
        reclaim0   = fl.commits0_valid && fl.commits0_need_free;
        reclaim1   = fl.commits1_valid && fl.commits1_need_free;
        reclaimCnt = {1'b0, reclaim0} + {1'b0, reclaim1};
        firstWe    = reclaim0 || reclaim1;
        firstData  = reclaim0 ? fl.commits0_old_prd : fl.commits1_old_prd;
        secondWe   = reclaim0 && reclaim1;
        secondData = fl.commits1_old_prd;
        tailPlus1  = flPtrAdd(tail_q, 2'd1);
    end

    // Next-state pointers. Redirect snaps the speculative head to the
    // committed head including this cycle's commits, discarding every
    // allocation not yet covered by a committed instruction.
    always_comb begin
        archHead_d = flPtrAdd(archHead_q, reclaimCnt);
        tail_d     = flPtrAdd(tail_q, reclaimCnt);
        specHead_d = fl.redirect_valid ? archHead_d
                                       : flPtrAdd(specHead_q, allocCnt);
    end

    // One-hot per-entry write enables. The two write slots always land on
    // distinct consecutive entries, so the decodes never overlap.
    always_comb begin
        entryWeFirst  = '0;
        entryWeSecond = '0;
        for (int i = 0; i < FL_SIZE; i++) begin
            entryWeFirst[i]  = firstWe  && (tail_q.idx    == FL_SIZE_LOG'(i));
            entryWeSecond[i] = secondWe && (tailPlus1.idx == FL_SIZE_LOG'(i));
        end
    end

    // Pointer registers, no enable: they reload their next value every
    // cycle. Reset leaves the list full (tail one lap ahead of the heads).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            specHead_q <= '{flag: 1'b0, idx: '0};
            archHead_q <= '{flag: 1'b0, idx: '0};
            tail_q     <= '{flag: 1'b1, idx: '0};
        end else begin
            specHead_q <= specHead_d;
            archHead_q <= archHead_d;
            tail_q     <= tail_d;
        end
    end

    // Entry storage. Reset seeds entry i with preg ARCH_REGS+i so every
    // non-architectural preg starts out free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                entries_q[i] <= preg_t'(ARCH_REGS + i);
            end
        end else begin
            for (int i = 0; i < FL_SIZE; i++) begin
                if (entryWeFirst[i]) begin
                    entries_q[i] <= firstData;
                end else if (entryWeSecond[i]) begin
                    entries_q[i] <= secondData;
                end
            end
        end
    end

endmodule

// File: tb/tb_freelist.sv
// ----------------------------------------------------------------------------
// tb_freelist
// Directed bench for freelist. Expected outputs come from a small reference
// model of the ring and are queued when each step is driven, then popped and
// compared against the DUT just after the inputs settle. Fixed-value spot
// checks pin the key scenarios independently of the model.
// ----------------------------------------------------------------------------
module tb_freelist;
    import freelist_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    int         mEntry [FL_SIZE];
    logic [5:0] mSpec, mArch, mTail;

    freelist_if fl();

    freelist dut (
        .clock   (clock),
        .reset_n (reset_n),
        .fl      (fl)
    );

    // Free-running clock, period 10; inputs change on the falling edge.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] observe(input string tag);
        if (tag == "alloc_ready") return {31'b0, fl.alloc_ready};
        if (tag == "alloc0_prd")  return {26'b0, fl.alloc0_prd};
        if (tag == "alloc1_prd")  return {26'b0, fl.alloc1_prd};
        if (tag == "free_count")  return {26'b0, fl.free_count};
        return 32'hdead_beef;
    endfunction

    task automatic pushExp(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.tag);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idleInputs();
        fl.alloc0_req         = 1'b0;
        fl.alloc1_req         = 1'b0;
        fl.commits0_valid     = 1'b0;
        fl.commits0_need_free = 1'b0;
        fl.commits0_old_prd   = '0;
        fl.commits1_valid     = 1'b0;
        fl.commits1_need_free = 1'b0;
        fl.commits1_old_prd   = '0;
        fl.redirect_valid     = 1'b0;
    endtask

    task automatic modelReset();
        for (int i = 0; i < FL_SIZE; i++) mEntry[i] = ARCH_REGS + i;
        mSpec = 6'd0;
        mArch = 6'd0;
        mTail = 6'd32;
    endtask

    // Drive one cycle of stimulus, queue the model's view of the
    // combinational outputs, compare, then advance the model and the clock.
    task automatic applyStimulus(input bit a0, input bit a1,
                                 input bit c0v, input bit c0n, input int c0p,
                                 input bit c1v, input bit c1n, input int c1p,
                                 input bit red);
        logic [5:0] fc;
        logic [5:0] p1ptr;
        logic [5:0] tp1;
        bit         rdy, f0, f1, r0, r1;

        fl.alloc0_req         = a0;
        fl.alloc1_req         = a1;
        fl.commits0_valid     = c0v;
        fl.commits0_need_free = c0n;
        fl.commits0_old_prd   = 6'(c0p);
        fl.commits1_valid     = c1v;
        fl.commits1_need_free = c1n;
        fl.commits1_old_prd   = 6'(c1p);
        fl.redirect_valid     = red;

        fc    = mTail - mSpec;
        rdy   = (fc >= 6'd2) && !red;
        p1ptr = mSpec + {5'b0, a0};
        pushExp("alloc_ready", int'(rdy));
        pushExp("alloc0_prd",  mEntry[mSpec[4:0]]);
        pushExp("alloc1_prd",  mEntry[p1ptr[4:0]]);
        pushExp("free_count",  int'(fc));
        #1;
        checkOutput();

        f0  = a0 && rdy;
        f1  = a1 && rdy;
        r0  = c0v && c0n;
        r1  = c1v && c1n;
        tp1 = mTail + 6'd1;
        if (r0 && r1) begin
            mEntry[mTail[4:0]] = c0p;
            mEntry[tp1[4:0]]   = c1p;
        end else if (r0) begin
            mEntry[mTail[4:0]] = c0p;
        end else if (r1) begin
            mEntry[mTail[4:0]] = c1p;
        end
        mTail = mTail + 6'(r0) + 6'(r1);
        mArch = mArch + 6'(r0) + 6'(r1);
        mSpec = red ? mArch : (mSpec + 6'(f0) + 6'(f1));
        if (6'(mTail - mSpec) > 6'd32) begin
            errors++;
            $display("[TB] FAIL overflow observed=%0d expected<=32", 6'(mTail - mSpec));
        end

        @(posedge clock);
        @(negedge clock);
    endtask

    // Fixed-value check of the current outputs with idle inputs except
    // alloc0_req, which selects what alloc1_prd shows.
    task automatic spotCheck(input bit a0, input int expReady, input int expCount,
                             input int expP0, input int expP1);
        idleInputs();
        fl.alloc0_req = a0;
        #1;
        pushExp("alloc_ready", expReady);
        pushExp("free_count",  expCount);
        pushExp("alloc0_prd",  expP0);
        pushExp("alloc1_prd",  expP1);
        checkOutput();
    endtask

    // Assert reset and check the outputs recover asynchronously, before
    // any clock edge, then release on a falling edge.
    task automatic doReset();
        reset_n = 1'b0;
        modelReset();
        spotCheck(1'b0, 1, 32, 32, 32);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Directed scenario sequence.
    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b1;
        idleInputs();
        modelReset();
        @(negedge clock);

        $display("[TB] reset then dual allocation");
        doReset();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        spotCheck(1'b1, 1, 30, 34, 35);

        $display("[TB] mid-operation reset, lone instr1 allocation");
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        spotCheck(1'b0, 1, 31, 33, 33);

        $display("[TB] drain to one free entry");
        for (int i = 0; i < 15; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        spotCheck(1'b0, 0, 1, 63, 63);
        applyStimulus(0, 0, 1, 1, 5, 0, 0, 0, 0);
        spotCheck(1'b1, 1, 2, 63, 5);

        $display("[TB] wrap-around");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        spotCheck(1'b0, 0, 0, 33, 33);
        applyStimulus(1, 1, 1, 1, 10, 1, 1, 11, 0);
        spotCheck(1'b1, 1, 2, 10, 11);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        spotCheck(1'b0, 0, 0, 35, 35);

        $display("[TB] redirect with same-cycle commit");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 3, 1, 1, 4, 0);
        applyStimulus(1, 1, 1, 1, 7, 0, 0, 0, 1);
        spotCheck(1'b1, 1, 32, 35, 36);

        $display("[TB] simultaneous dual alloc and commit");
        applyStimulus(1, 1, 1, 1, 20, 1, 0, 21, 0);
        spotCheck(1'b1, 1, 31, 37, 38);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
